matcher_list_scanner: RTL
=========================

MATCHER_LIST_SCANNER -- requirements
Module: matcher_list_scanner

Interface
REQ-001 The block SHALL have parameter LIST_WIDTH, default 10, ROM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, ROM entry and key width.
REQ-003 The block SHALL have parameter LIST_LEN, default 2**LIST_WIDTH, number of entries scanned (1..2**LIST_WIDTH).
REQ-004 The block SHALL have port fclk, input, 1 bit, sole clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port key_valid, input, 1 bit, search key offered.
REQ-007 The block SHALL have port key_ready, output, 1 bit, block accepts key this cycle.
REQ-008 The block SHALL have port key_data, input, DATA_WIDTH bits, search key.
REQ-009 The block SHALL have port rom_en, output, 1 bit, ROM read enable.
REQ-010 The block SHALL have port rom_addr, output, LIST_WIDTH bits, ROM read address.
REQ-011 The block SHALL have port rom_data, input, DATA_WIDTH bits, ROM output: registered, valid one cycle after rom_en/rom_addr sampled, zero when not enabled.
REQ-012 The block SHALL have port res_valid, output, 1 bit, result available.
REQ-013 The block SHALL have port res_ready, input, 1 bit, consumer takes result.
REQ-014 The block SHALL have port res_hit, output, 1 bit, key found.
REQ-015 The block SHALL have port res_index, output, LIST_WIDTH bits, index of first matching entry.
REQ-016 The block SHALL have port busy, output, 1 bit, high when not IDLE.

Function
REQ-017 The block SHALL implement states IDLE, SCAN, DONE.
REQ-018 In IDLE, key_ready SHALL be 1; in SCAN and DONE it SHALL be 0.
REQ-019 On key_valid&&key_ready in cycle T, the key SHALL be registered and the state SHALL go to SCAN at T+1.
REQ-020 In SCAN the block SHALL drive rom_en=1 and rom_addr=0,1,2,... one per cycle starting at T+1, stopping after LIST_LEN-1 is issued or on a hit.
REQ-021 A one-bit compare-valid pipeline flag and a registered index tag SHALL track each issued address; compare SHALL occur only when the flag is set (zero ROM output while disabled never counts as data).
REQ-022 Compare SHALL be full-width equality of rom_data and registered key.
REQ-023 On the first compare hit for index i (data valid cycle T+2+i), the block SHALL go to DONE with res_hit=1, res_index=i, res_valid=1 at T+3+i; any address issued after i SHALL be discarded.
REQ-024 If index LIST_LEN-1 compares without hit, the block SHALL go to DONE with res_hit=0, res_index=0, res_valid=1 at T+LIST_LEN+2.
REQ-025 Outside SCAN, rom_en SHALL be 0 and rom_addr 0.
REQ-026 In DONE, res_valid, res_hit, res_index SHALL hold stable until res_ready=1; on that cycle state SHALL return to IDLE and res_valid SHALL drop next cycle.
REQ-027 A new key SHALL not be accepted in the same cycle a result is consumed; key_ready rises the cycle after.
REQ-028 Duplicate entries SHALL report the lowest index.
REQ-029 The address counter SHALL be LIST_WIDTH bits and never wrap within a scan; LIST_LEN=2**LIST_WIDTH SHALL end at all-ones without overflow.
REQ-030 key_valid while busy SHALL be ignored, key_data not sampled.

Reset
REQ-031 With rst=1 at a rising edge, next cycle SHALL show state IDLE, key_ready=1, busy=0, rom_en=0, rom_addr=0, res_valid=0, res_hit=0, res_index=0, compare-valid flag 0, key register 0.
REQ-032 rst SHALL win over every other event, including mid-SCAN and in DONE; the pending result SHALL be lost and no stale compare SHALL produce a result after reset.

Verification (LIST_WIDTH=3, LIST_LEN=8, ROM entry k = 0x100+k)
REQ-033 Key 0x103 accepted at T -> rom_addr 0..3 (or 0..4) issued from T+1, res_valid=1, res_hit=1, res_index=3 at T+6.
REQ-034 Key 0x0 accepted at T -> all 8 addresses issued, res_hit=0, res_index=0, res_valid at T+10; zero ROM output while disabled never hits.
REQ-035 Key 0x107 (last entry) -> res_hit=1, res_index=7 at T+10, rom_addr never exceeds 7.
REQ-036 res_ready held 0 for 5 cycles in DONE -> outputs stable, key_ready=0; res_ready=1 -> IDLE, key_ready=1 next cycle.
REQ-037 Entries 2 and 5 set to 0x0AA, key 0x0AA -> res_index=2.
REQ-038 rst pulsed at T+3 of a scan for 0x106 -> all outputs at reset values next cycle, no res_valid; following key 0x101 -> res_index=1 with normal latency.

Source files
------------

// File: rtl/matcher_list_scanner.sv
// matcher_list_scanner: linear search of a registered-output ROM for the first entry equal to a key
module matcher_list_scanner #(
  parameter int LIST_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LIST_LEN   = 2**LIST_WIDTH
) (
  input  logic                  fclk,
  input  logic                  rst,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [DATA_WIDTH-1:0] key_data,
  output logic                  rom_en,
  output logic [LIST_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_hit,
  output logic [LIST_WIDTH-1:0] res_index,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [LIST_WIDTH-1:0] LAST_IDX = LIST_WIDTH'(LIST_LEN - 1);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] key_q;
  logic [LIST_WIDTH-1:0] addr_q, tag_q, res_index_q;
  logic issued_all_q, cv_q, res_hit_q;
  logic accept, hit, last;
  assign accept = state_q == IDLE && key_valid;
  assign hit    = state_q == SCAN && cv_q && rom_data == key_q;
  assign last   = state_q == SCAN && cv_q && tag_q == LAST_IDX;
  always_ff @(posedge fclk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    if (accept) state_d = SCAN;
    else if (hit || last) state_d = DONE;
    else if (state_q == DONE && res_ready) state_d = IDLE;
  end
  always_comb begin
    key_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    rom_en    = state_q == SCAN && !issued_all_q;
    rom_addr  = rom_en ? addr_q : '0;
    res_valid = state_q == DONE;
    res_hit   = res_hit_q;
    res_index = res_index_q;
  end
  // cv_q/tag_q follow each issued address by one cycle, aligned with rom_data
  always_ff @(posedge fclk) begin
    if (rst) begin
      key_q        <= '0;
      addr_q       <= '0;
      tag_q        <= '0;
      cv_q         <= 1'b0;
      issued_all_q <= 1'b0;
      res_hit_q    <= 1'b0;
      res_index_q  <= '0;
    end else begin
      cv_q  <= rom_en;
      tag_q <= addr_q;
      if (accept) begin
        key_q        <= key_data;
        addr_q       <= '0;
        issued_all_q <= 1'b0;
      end else if (rom_en) begin
        if (addr_q == LAST_IDX) issued_all_q <= 1'b1;
        else addr_q <= addr_q + 1'b1;
      end
      if (hit) begin
        res_hit_q   <= 1'b1;
        res_index_q <= tag_q;
      end else if (last || (state_q == DONE && res_ready)) begin
        res_hit_q   <= 1'b0;
        res_index_q <= '0;
      end
    end
  end
endmodule
